// File: rtl/mmio_timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared constants and types for the memory-mapped timer:
//   - word offsets of the registers inside the 32-byte window
//   - bit positions of the CTRL fields
//   - packed CTRL struct and a helper that extracts it from a bus word
// -----------------------------------------------------------------------------
package timer_pkg;

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_COUNT    = 3'd1;
  localparam logic [2:0] OFF_COMPARE  = 3'd2;
  localparam logic [2:0] OFF_STATUS   = 3'd3;
  localparam logic [2:0] OFF_PRESCALE = 3'd4;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_AUTO  = 1;
  localparam int CTRL_IRQEN = 2;

  // Field order matches the CTRL bit indices (irqen is bit 2, en is bit 0).
  typedef struct packed {
    logic irqen;
    logic autoreload;
    logic en;
  } ctrl_t;

  function automatic ctrl_t ctrl_from_word(input logic [31:0] w);
    ctrl_t c;
    c.en         = w[CTRL_EN];
    c.autoreload = w[CTRL_AUTO];
    c.irqen      = w[CTRL_IRQEN];
    return c;
  endfunction

endpackage

// File: rtl/mmio_timer_if.sv
// -----------------------------------------------------------------------------
// mmio_timer_if
// CPU memory-bus signals as seen between the CPU (master) and a memory-mapped
// target (slave).
//   Address [31:0] : byte address from the CPU
//   Wr             : 1 = write this cycle, 0 = read
//   Datain  [31:0] : write data from the CPU
//   Dataout [31:0] : registered read data from the target
//   hit            : target claims the access; Dataout valid this cycle
// -----------------------------------------------------------------------------
interface mmio_timer_if;

  logic [31:0] Address;
  logic        Wr;
  logic [31:0] Datain;
  logic [31:0] Dataout;
  logic        hit;

  modport master (
    output Address,
    output Wr,
    output Datain,
    input  Dataout,
    input  hit
  );

  modport slave (
    input  Address,
    input  Wr,
    input  Datain,
    output Dataout,
    output hit
  );

endinterface

// File: rtl/mmio_timer_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Prescaler for the timer. While enabled, the internal counter advances every
// cycle and wraps to 0 when it equals the divisor, producing a one-cycle tick.
// A divisor of 0 therefore ticks every enabled cycle.
//   clock   : system clock
//   reset   : asynchronous, active-high
//   enable  : advance the prescaler (timer EN)
//   divisor : wrap value of the prescaler counter
//   clear   : force the prescaler counter back to 0 (divisor rewritten)
//   tick    : combinational, high in the cycle the counter equals the divisor
// -----------------------------------------------------------------------------
module tick_gen #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] divisor,
  input  logic                  clear,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] r_pcnt;

  assign tick = enable && (r_pcnt == divisor);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pcnt <= '0;
    end else if (clear) begin
      r_pcnt <= '0;
    end else if (enable) begin
      r_pcnt <= tick ? '0 : r_pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// -----------------------------------------------------------------------------
// mmio_timer
// Memory-mapped timer on the CPU memory bus. Decodes a 32-byte window at BASE,
// holds CTRL / COUNT / COMPARE / STATUS / PRESCALE, counts prescaled ticks,
// flags a compare match and drives a level interrupt.
//   clock : system clock, all state on rising edge
//   reset : asynchronous, active-high
//   bus   : slave side of the memory bus (Address, Wr, Datain in;
//           Dataout, hit out, both registered with one cycle of latency)
//   irq   : level interrupt, MATCH & IRQEN
// Register map (word offsets): 0 CTRL, 1 COUNT, 2 COMPARE, 3 STATUS (W1C
// MATCH), 4 PRESCALE, 5-7 read as 0.
// -----------------------------------------------------------------------------
module mmio_timer
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE       = 32'hFFFF_FF00,
  parameter int          PRESCALE_W = 16
) (
  input  logic         clock,
  input  logic         reset,
  mmio_timer_if.slave  bus,
  output logic         irq
);

  ctrl_t                 r_ctrl;
  logic [31:0]           r_count;
  logic [31:0]           r_compare;
  logic                  r_match;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [31:0]           r_dout;
  logic                  r_hit;
  logic                  r_irq;

  logic                  w_in_win;
  logic [2:0]            w_off;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_wr_ctrl;
  logic                  w_wr_count;
  logic                  w_wr_compare;
  logic                  w_wr_status;
  logic                  w_wr_prescale;
  logic                  w_tick;
  logic                  w_match_evt;
  ctrl_t                 w_ctrl_nx;
  logic [31:0]           w_count_nx;
  logic                  w_match_nx;
  logic                  w_irq_nx;
  logic [31:0]           w_rdata;

  // Address decode; the two byte-lane bits are ignored (word access only).
  assign w_in_win      = (bus.Address[31:5] == BASE[31:5]);
  assign w_off         = bus.Address[4:2];
  assign w_wr          = w_in_win && bus.Wr;
  assign w_rd          = w_in_win && !bus.Wr;
  assign w_wr_ctrl     = w_wr && (w_off == OFF_CTRL);
  assign w_wr_count    = w_wr && (w_off == OFF_COUNT);
  assign w_wr_compare  = w_wr && (w_off == OFF_COMPARE);
  assign w_wr_status   = w_wr && (w_off == OFF_STATUS);
  assign w_wr_prescale = w_wr && (w_off == OFF_PRESCALE);

  tick_gen #(
    .PRESCALE_W (PRESCALE_W)
  ) u_tick_gen (
    .clock   (clock),
    .reset   (reset),
    .enable  (r_ctrl.en),
    .divisor (r_prescale),
    .clear   (w_wr_prescale),
    .tick    (w_tick)
  );

  // A match is judged on the pre-write COUNT, so it still fires even when
  // software overwrites COUNT or CTRL in the same cycle.
  assign w_match_evt = w_tick && (r_count == r_compare);

  always_comb begin
    w_ctrl_nx  = r_ctrl;
    w_count_nx = r_count;
    w_match_nx = r_match;

    // Tick-driven COUNT update is dropped when software writes COUNT or CTRL.
    if (w_tick && !w_wr_count && !w_wr_ctrl) begin
      if (w_match_evt) begin
        if (r_ctrl.autoreload) begin
          w_count_nx = '0;
        end
      end else begin
        w_count_nx = r_count + 32'd1;
      end
    end

    // One-shot: a match without autoreload stops the timer, COUNT rests at
    // COMPARE.
    if (w_match_evt && !r_ctrl.autoreload) begin
      w_ctrl_nx.en = 1'b0;
    end

    if (w_wr_ctrl) begin
      w_ctrl_nx = ctrl_from_word(bus.Datain);
    end
    if (w_wr_count) begin
      w_count_nx = bus.Datain;
    end

    // Set beats write-1-to-clear when both land in the same cycle.
    if (w_wr_status && bus.Datain[0]) begin
      w_match_nx = 1'b0;
    end
    if (w_match_evt) begin
      w_match_nx = 1'b1;
    end

    w_irq_nx = w_match_nx && w_ctrl_nx.irqen;
  end

  // Read mux always sees the pre-update register values.
  always_comb begin
    w_rdata = '0;
    case (w_off)
      OFF_CTRL:     w_rdata = {29'd0, r_ctrl};
      OFF_COUNT:    w_rdata = r_count;
      OFF_COMPARE:  w_rdata = r_compare;
      OFF_STATUS:   w_rdata = {31'd0, r_match};
      OFF_PRESCALE: w_rdata = 32'(r_prescale);
      default:      w_rdata = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ctrl     <= '0;
      r_count    <= '0;
      r_compare  <= '0;
      r_match    <= 1'b0;
      r_prescale <= '0;
      r_dout     <= '0;
      r_hit      <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_ctrl    <= w_ctrl_nx;
      r_count   <= w_count_nx;
      r_match   <= w_match_nx;
      r_irq     <= w_irq_nx;
      if (w_wr_compare) begin
        r_compare <= bus.Datain;
      end
      if (w_wr_prescale) begin
        r_prescale <= bus.Datain[PRESCALE_W-1:0];
      end
      r_dout <= w_rd ? w_rdata : 32'd0;
      r_hit  <= w_rd;
    end
  end

  assign bus.Dataout = r_dout;
  assign bus.hit     = r_hit;
  assign irq         = r_irq;

endmodule

// File: tb/tb_mmio_timer.sv
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;

  logic clk = 1'b0;
  logic rst;
  logic irq;

  mmio_timer_if bus ();

  mmio_timer #(
    .BASE       (BASE),
    .PRESCALE_W (16)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state (behavioural, plain integers)
  logic [31:0] m_count, m_compare, m_dout;
  bit          m_en, m_auto, m_irqen, m_match, m_hit, m_irq;
  int          m_prescale, m_pcnt;

  function automatic logic [31:0] A(input int k);
    return BASE + 32'(4 * k);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_count = 0; m_compare = 0; m_dout = 0;
    m_en = 0; m_auto = 0; m_irqen = 0; m_match = 0; m_hit = 0; m_irq = 0;
    m_prescale = 0; m_pcnt = 0;
  endfunction

  // One clock edge of the timer, computed from the register-map rules.
  function automatic void model_step(input logic [31:0] a, input logic w, input logic [31:0] d);
    bit          inwin, rd, wr, tick, fire;
    int          off;
    logic [31:0] rv;
    logic [32:0] inc;
    logic [31:0] n_count;
    bit          n_en, n_auto, n_irqen, n_match;
    int          n_pcnt;
    inwin = (a[31:5] == BASE[31:5]);
    off   = int'(a[4:2]);
    rd    = inwin && !w;
    wr    = inwin && w;
    case (off)
      0: rv = {29'd0, m_irqen, m_auto, m_en};
      1: rv = m_count;
      2: rv = m_compare;
      3: rv = {31'd0, m_match};
      4: rv = 32'(m_prescale);
      default: rv = 0;
    endcase
    tick = m_en && (m_pcnt == m_prescale);
    fire = tick && (m_count == m_compare);

    n_count = m_count; n_en = m_en; n_auto = m_auto; n_irqen = m_irqen; n_match = m_match;
    if (wr && off == 4) n_pcnt = 0;
    else if (m_en)      n_pcnt = tick ? 0 : m_pcnt + 1;
    else                n_pcnt = m_pcnt;

    if (tick && !(wr && (off == 0 || off == 1))) begin
      if (fire) n_count = m_auto ? 32'd0 : m_count;
      else begin
        inc = {1'b0, m_count} + 33'd1;
        n_count = inc[31:0];
      end
    end
    if (fire && !m_auto) n_en = 0;
    if (wr && off == 0) begin n_en = d[0]; n_auto = d[1]; n_irqen = d[2]; end
    if (wr && off == 1) n_count = d;
    if (wr && off == 2) m_compare = d;
    if (wr && off == 4) m_prescale = int'(d[15:0]);
    if (wr && off == 3 && d[0]) n_match = 0;
    if (fire) n_match = 1;

    m_count = n_count; m_en = n_en; m_auto = n_auto; m_irqen = n_irqen;
    m_match = n_match; m_pcnt = n_pcnt;
    m_irq  = m_match && m_irqen;
    m_dout = rd ? rv : 32'd0;
    m_hit  = rd;
  endfunction

  task automatic op(input logic [31:0] a, input logic w, input logic [31:0] d, input string tag);
    @(negedge clk);
    bus.Address = a;
    bus.Wr      = w;
    bus.Datain  = d;
    model_step(a, w, d);
    @(posedge clk);
    #1;
    check({tag, ".dout"}, bus.Dataout, m_dout);
    check({tag, ".hit"}, {31'd0, bus.hit}, {31'd0, m_hit});
    check({tag, ".irq"}, {31'd0, irq}, {31'd0, m_irq});
  endtask

  task automatic rd(input int k, input string tag);
    op(A(k), 1'b0, 32'd0, tag);
  endtask

  task automatic wr(input int k, input logic [31:0] d, input string tag);
    op(A(k), 1'b1, d, tag);
  endtask

  initial begin
    logic [31:0] exp_seq [6];
    logic [31:0] a, d;
    logic        w;
    int          k;

    rst = 1'b1;
    bus.Address = 32'd0; bus.Wr = 1'b0; bus.Datain = 32'd0;
    model_reset();
    @(posedge clk); #1;
    check("rst.dout", bus.Dataout, 32'd0);
    check("rst.hit", {31'd0, bus.hit}, 32'd0);
    check("rst.irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;

    // 1: every offset reads 0 after reset with hit; out-of-window gives no hit
    for (int i = 0; i < 8; i++) begin
      rd(i, "t1.rd");
      check("t1.zero", bus.Dataout, 32'd0);
      check("t1.hit", {31'd0, bus.hit}, 32'd1);
    end
    op(32'h0000_0010, 1'b0, 32'd0, "t1.out");
    check("t1.out_hit", {31'd0, bus.hit}, 32'd0);

    // 2: autoreload with interrupt
    wr(4, 32'd0, "t2.ps");
    wr(2, 32'd5, "t2.cmp");
    wr(0, 32'd7, "t2.ctrl");
    for (int i = 0; i < 6; i++) begin
      rd(1, "t2.cnt");
      check("t2.cnt_val", bus.Dataout, 32'(i));
    end
    check("t2.irq_set", {31'd0, irq}, 32'd1);
    rd(1, "t2.reload");
    check("t2.reload_val", bus.Dataout, 32'd0);
    rd(3, "t2.status");
    check("t2.match", bus.Dataout, 32'd1);
    wr(3, 32'd1, "t2.w1c");
    check("t2.irq_clr", {31'd0, irq}, 32'd0);
    wr(0, 32'd0, "t2.stop");

    // 3: prescaled one-shot, no interrupt
    wr(4, 32'd3, "t3.ps");
    wr(2, 32'd2, "t3.cmp");
    wr(1, 32'd0, "t3.cnt0");
    wr(3, 32'd1, "t3.clr");
    wr(0, 32'd1, "t3.ctrl");
    for (int i = 0; i < 16; i++) rd(1, "t3.cnt");
    check("t3.final", bus.Dataout, 32'd2);
    rd(0, "t3.ctrl_rd");
    check("t3.en_off", bus.Dataout, 32'd0);
    rd(3, "t3.status");
    check("t3.match", bus.Dataout, 32'd1);
    check("t3.no_irq", {31'd0, irq}, 32'd0);

    // 4: wrap without match, then match at 3
    wr(3, 32'd1, "t4.clr");
    wr(4, 32'd0, "t4.ps");
    wr(1, 32'hFFFF_FFFE, "t4.cnt");
    wr(2, 32'd3, "t4.cmp");
    wr(0, 32'd1, "t4.ctrl");
    exp_seq[0] = 32'hFFFF_FFFE; exp_seq[1] = 32'hFFFF_FFFF; exp_seq[2] = 32'd0;
    for (int i = 0; i < 3; i++) begin
      rd(1, "t4.cnt");
      check("t4.cnt_val", bus.Dataout, exp_seq[i]);
    end
    rd(3, "t4.nowrap");
    check("t4.nowrap_match", bus.Dataout, 32'd0);
    rd(1, "t4.cnt2");
    check("t4.cnt2_val", bus.Dataout, 32'd2);
    rd(1, "t4.cnt3");
    check("t4.cnt3_val", bus.Dataout, 32'd3);
    rd(3, "t4.status");
    check("t4.match", bus.Dataout, 32'd1);

    // 5a: COUNT write on a tick cycle wins
    wr(3, 32'd1, "t5.clr");
    wr(2, 32'd1000, "t5.cmp");
    wr(1, 32'd7, "t5.cnt");
    wr(0, 32'd1, "t5.ctrl");
    rd(1, "t5.run");
    wr(1, 32'd100, "t5.collide");
    rd(1, "t5.after");
    check("t5.count100", bus.Dataout, 32'd100);

    // 5b: W1C on the match cycle loses to the set
    wr(0, 32'd0, "t5.stop");
    wr(2, 32'd3, "t5.cmp3");
    wr(1, 32'd0, "t5.cnt0");
    wr(0, 32'd3, "t5.auto");
    rd(1, "t5.c0");
    rd(1, "t5.c1");
    rd(1, "t5.c2");
    wr(3, 32'd1, "t5.w1c_match");
    rd(3, "t5.status");
    check("t5.match_kept", bus.Dataout, 32'd1);

    // 6: asynchronous reset between edges
    wr(0, 32'd0, "t6.stop");
    wr(4, 32'd0, "t6.ps");
    wr(2, 32'd0, "t6.cmp");
    wr(1, 32'd0, "t6.cnt");
    wr(0, 32'd7, "t6.ctrl");
    rd(1, "t6.run0");
    rd(1, "t6.run1");
    check("t6.irq_pre", {31'd0, irq}, 32'd1);
    check("t6.hit_pre", {31'd0, bus.hit}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("t6.dout", bus.Dataout, 32'd0);
    check("t6.hit", {31'd0, bus.hit}, 32'd0);
    check("t6.irq", {31'd0, irq}, 32'd0);
    check("t6.count", dut.r_count, 32'd0);
    check("t6.ctrl", {29'd0, dut.r_ctrl}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    rd(1, "t6.cnt_rd");
    check("t6.cnt_zero", bus.Dataout, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      k = int'($urandom_range(0, 7));
      w = ($urandom_range(0, 2) == 0);
      case (k)
        0:       d = 32'($urandom_range(0, 7)) | 32'($urandom_range(0, 1));
        1:       d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFD : 32'($urandom_range(0, 12));
        2:       d = 32'($urandom_range(0, 12));
        4:       d = 32'($urandom_range(0, 3)) | ($urandom & 32'hFFFF_0000);
        default: d = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = $urandom & 32'h7FFF_FFFF;
      else a = A(k) + 32'($urandom_range(0, 3));
      op(a, w, d, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
- Memory-mapped responder for the CPU's memory bus: same Address/Wr/Datain/Dataout protocol the CPU drives toward main memory, seen from the target side.
- Decodes a 32-byte window, holds a programmable prescaled up-counter with compare/match, and raises a level interrupt line for the control unit's exception path.
- The top level muxes Dataout onto the CPU read path when hit is high.

Parameters:
BASE, 32'hFFFF_FF00, byte base address of the register window (32-byte aligned)
PRESCALE_W, 16, width of prescaler divisor register and its counter

Ports:
clock  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-high reset
Address  input  32  byte address from CPU address mux
Wr  input  1  1 = write this cycle, 0 = read
Datain  input  32  write data from CPU
Dataout  output  32  registered read data
hit  output  1  registered; 1 when Dataout holds data for an in-window access
irq  output  1  level interrupt to control unit

Behaviour:
- Reset: all registers 0; Dataout=0, hit=0, irq=0; the prescaler counter is also 0. Reset asserted mid-count aborts immediately, with no pending match.
- Decode: in_win = (Address[31:5] == BASE[31:5]); offset = Address[4:2]; Address[1:0] ignored (word access only).
- Register map (offset: name, access):
  - 0 CTRL rw: bit0 EN, bit1 AUTORELOAD, bit2 IRQEN; bits 31:3 read 0.
  - 1 COUNT rw: 32-bit counter.
  - 2 COMPARE rw: 32-bit.
  - 3 STATUS: bit0 MATCH; writing 1 to bit0 clears it, writing 0 has no effect.
  - 4 PRESCALE rw: low PRESCALE_W bits; upper bits read 0.
  - 5-7: read 0, writes ignored.
- Write: when in_win && Wr at a rising edge, the register update is visible from the next cycle. Out-of-window writes are ignored.
- Read latency is 1 cycle, matching main memory:
  - in_win && !Wr at edge N → Dataout = register value before edge N's updates, and hit = 1 during cycle N+1.
  - Otherwise Dataout = 0 and hit = 0 in the next cycle.
  - A write cycle also gives hit = 0.
- Prescaler: when EN=1, pcnt increments each cycle. When pcnt == PRESCALE, pcnt←0 and tick=1. PRESCALE=0 gives a tick every cycle. EN=0 holds pcnt and COUNT.
- Counting on tick:
  - If COUNT == COMPARE: MATCH←1; COUNT←0 if AUTORELOAD, else COUNT holds at COMPARE and EN←0 (one-shot).
  - Otherwise COUNT←COUNT+1, wrapping 0xFFFFFFFF→0 without setting MATCH.
- irq = MATCH & IRQEN (registered, from state); it drops the cycle after MATCH is cleared or IRQEN is cleared.
- Simultaneous events:
  - A software write to COUNT or CTRL in the same cycle as a tick: the software write wins and the tick's COUNT update is discarded. MATCH may still set if the pre-write COUNT == COMPARE.
  - W1C to MATCH in the same cycle as a new match: set wins, so MATCH stays 1.
  - A write to PRESCALE resets pcnt to 0.
  - A write to CTRL with EN 0→1 does not reset COUNT.

Decomposition:
- Package timer_pkg:
  - Offset constants OFF_CTRL=3'd0, OFF_COUNT=3'd1, OFF_COMPARE=3'd2, OFF_STATUS=3'd3, OFF_PRESCALE=3'd4.
  - CTRL bit indices CTRL_EN=0, CTRL_AUTO=1, CTRL_IRQEN=2.
  - Packed struct typedef for CTRL.
- Sub-module tick_gen:
  - Inputs: clock, reset, enable, divisor, clear.
  - Output: tick.
  - Contains the prescaler counter.
- The top module holds decode, the register file, count/compare logic and the read register.

Test Plan:
1. Reset, then read each offset 0-7 at BASE+4k → Dataout=0 and hit=1 one cycle later. Read 32'h0000_0010 → hit=0, Dataout=0.
2. Write PRESCALE=0, COMPARE=5, CTRL=3'b111 → COUNT goes 0,1,..,5 on consecutive cycles. MATCH=1 and irq=1 the cycle after the 5→compare tick, and COUNT returns to 0. Write STATUS=1 → irq=0 next cycle.
3. Write PRESCALE=3, COMPARE=2, CTRL=3'b001 (one-shot, no irq):
   - COUNT increments every 4 cycles and stops at 2.
   - MATCH=1, EN reads 0, irq stays 0.
4. Write COUNT=32'hFFFF_FFFE, COMPARE=3, PRESCALE=0, EN=1 → COUNT goes FFFF_FFFE, FFFF_FFFF, 0, 1, 2, 3. No MATCH on wrap; MATCH sets at 3.
5. Collisions:
   - Write COUNT=100 on a tick cycle → next read returns 100.
   - W1C STATUS on the exact match cycle → MATCH reads 1.
6. Assert reset asynchronously mid-count, between edges → COUNT, CTRL, irq, hit and Dataout are 0 immediately, before the next clock edge.
